timer_dev: RTL and testbench

Memory-mapped countdown timer that answers CPU load/store accesses from the MEM stage: the bus supplies address, byte enables, write data and write strobe, and the block returns read data combinationally. Three word registers (CTRL, PRESET, COUNT) are driven by a 4-state counting FSM that raises an interrupt request on expiry. It sits behind the system bridge alongside DM, in the same address-decoded slot as any other peripheral.

---
 rtl/timer_dev.sv | 109 ++++++++++
 tb/tb_timer_dev.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT word registers, a four-state
// counting FSM, and an interrupt request that is sticky in one-shot mode.
module timer_dev (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic        WE,
  input  logic [3:0]  BE,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        IRQ
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      state, state_nx;
  logic [3:0]  ctrl, ctrl_nx;
  logic [31:0] preset, preset_nx;
  logic [31:0] count, count_nx;
  logic        pending, pending_nx;
  logic        irq_nx;
  logic        wr_ctrl, wr_preset;
  logic        en, auto_mode, enter_int, fsm_clr_en;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  lanes);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++)
      if (lanes[i]) res[8*i +: 8] = new_val[8*i +: 8];
    return res;
  endfunction

  always_comb begin
    wr_ctrl    = WE && (A[3:2] == 2'b00);
    wr_preset  = WE && (A[3:2] == 2'b01);
    en         = ctrl[0];
    auto_mode  = (ctrl[2:1] == 2'b01);
    state_nx   = state;
    count_nx   = count;
    enter_int  = 1'b0;
    fsm_clr_en = 1'b0;

    case (state)
      IDLE: if (en) state_nx = LOAD;
      LOAD: begin
        count_nx = preset;
        state_nx = CNT;
      end
      CNT: begin
        // Zero is tested before decrementing, so the count never wraps.
        if (!en)              state_nx = IDLE;
        else if (count == '0) begin
          state_nx  = INT;
          enter_int = 1'b1;
        end else              count_nx = count - 32'd1;
      end
      INT: begin
        if (auto_mode) state_nx = LOAD;
        else begin
          state_nx   = IDLE;
          fsm_clr_en = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    // A CPU write to the EN lane overrides the one-shot self-clear.
    ctrl_nx = fsm_clr_en ? {ctrl[3:1], 1'b0} : ctrl;
    if (wr_ctrl && BE[0]) ctrl_nx = WD[3:0];

    preset_nx = wr_preset ? merge_lanes(preset, WD, BE) : preset;

    if (wr_ctrl || wr_preset)       pending_nx = 1'b0;
    else if (enter_int && !auto_mode) pending_nx = 1'b1;
    else                            pending_nx = pending;

    irq_nx = ctrl_nx[3] && (pending_nx || (enter_int && auto_mode));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ctrl    <= '0;
      preset  <= '0;
      count   <= '0;
      pending <= 1'b0;
      IRQ     <= 1'b0;
    end else begin
      state   <= state_nx;
      ctrl    <= ctrl_nx;
      preset  <= preset_nx;
      count   <= count_nx;
      pending <= pending_nx;
      IRQ     <= irq_nx;
    end
  end

  always_comb begin
    case (A[3:2])
      2'b00:   RD = {28'd0, ctrl};
      2'b01:   RD = preset;
      2'b10:   RD = count;
      default: RD = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_dev.sv
// Bench for timer_dev: elapsed-time reference model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_timer_dev;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] A = '0;
  logic        WE = 1'b0;
  logic [3:0]  BE = '0;
  logic [31:0] WD = '0;
  logic [31:0] RD;
  logic        IRQ;

  int n_chk = 0;
  int n_fail = 0;

  timer_dev dut (.clk(clk), .reset(reset), .A(A), .WE(WE), .BE(BE), .WD(WD),
                 .RD(RD), .IRQ(IRQ));

  always #5 clk = ~clk;

  // Reference: while running, m_t counts edges since the LOAD cycle.
  // t=0 LOAD, t=1..L+1 counting (COUNT = L-(t-1)), t=L+2 expiry cycle.
  logic [3:0]  m_ctrl = '0;
  logic [31:0] m_preset = '0;
  logic [31:0] m_count = '0;
  bit          m_pend = 0, m_irq = 0, m_run = 0;
  longint      m_t = 0, m_L = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ctrl = '0; m_preset = '0; m_count = '0;
      m_pend = 0; m_irq = 0; m_run = 0; m_t = 0; m_L = 0;
    end else begin
      bit en, autom, expire, clr, wc, wp;
      en = m_ctrl[0];
      autom = (m_ctrl[2:1] == 2'b01);
      expire = 0;
      clr = 0;
      if (!m_run) begin
        if (en) begin m_run = 1; m_t = 0; end
      end else if (m_t == 0) begin
        m_L = longint'(m_preset);
        m_count = m_preset;
        m_t = 1;
      end else if (m_t <= m_L + 1) begin
        if (!en) m_run = 0;
        else if (m_t == m_L + 1) begin m_t = m_L + 2; expire = 1; end
        else begin m_t++; m_count = 32'(m_L - (m_t - 1)); end
      end else begin
        if (autom) m_t = 0;
        else begin m_run = 0; clr = 1; end
      end
      wc = WE && (A[3:2] == 2'b00);
      wp = WE && (A[3:2] == 2'b01);
      if (clr) m_ctrl[0] = 1'b0;
      if (wc && BE[0]) m_ctrl = WD[3:0];
      if (wp) for (int i = 0; i < 4; i++) if (BE[i]) m_preset[8*i +: 8] = WD[8*i +: 8];
      if (wc || wp) m_pend = 0;
      else if (expire && !autom) m_pend = 1;
      m_irq = m_ctrl[3] && (m_pend || (expire && autom));
    end
  end

  function automatic logic [31:0] m_rd(input logic [1:0] sel);
    case (sel)
      2'b00:   return {28'd0, m_ctrl};
      2'b01:   return m_preset;
      2'b10:   return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_rd", RD, m_rd(A[3:2]));
    check("model_irq", {31'd0, IRQ}, {31'd0, m_irq});
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
    A = addr; BE = be; WD = data; WE = 1'b1;
    step(1);
    WE = 1'b0; BE = '0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    A = addr;
    #1;
    check(name, RD, exp);
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    step(1);
    rd_chk("rst_ctrl", 32'h0, 32'h0);
    rd_chk("rst_preset", 32'h4, 32'h0);
    rd_chk("rst_count", 32'h8, 32'h0);
    rd_chk("rst_unused", 32'hC, 32'h0);
    check("rst_irq", {31'd0, IRQ}, 32'd0);

    // Byte lanes, read-only and unmapped writes.
    wr(32'h4, 4'b1111, 32'hAABBCCDD);
    wr(32'h5, 4'b0101, 32'h11223344);
    rd_chk("be_preset", 32'h4, 32'hAA22CC44);
    wr(32'h8, 4'b1111, 32'h12345678);
    rd_chk("count_ro", 32'h8, 32'h0);
    wr(32'hC, 4'b1111, 32'hFFFFFFFF);
    rd_chk("unused_ro", 32'hC, 32'h0);
    wr(32'h0, 4'b1111, 32'hFFFFFFF0);
    rd_chk("ctrl_upper", 32'h0, 32'h0);

    // One-shot, PRESET=5: COUNT=5 at edge 2, 0 at edge 7, IRQ after edge 8.
    wr(32'h4, 4'b1111, 32'd5);
    wr(32'h0, 4'b0001, 32'h9);
    step(2);
    rd_chk("os_count_n", 32'h8, 32'd5);
    step(5);
    rd_chk("os_count_0", 32'h8, 32'd0);
    check("os_irq_pre", {31'd0, IRQ}, 32'd0);
    step(1);
    check("os_irq_rise", {31'd0, IRQ}, 32'd1);
    step(2);
    check("os_irq_sticky", {31'd0, IRQ}, 32'd1);
    rd_chk("os_en_clr", 32'h0, 32'h8);
    wr(32'h0, 4'b0001, 32'h0);
    check("os_irq_clr", {31'd0, IRQ}, 32'd0);

    // Auto-reload, PRESET=3: pulses after edges 6 and 12.
    wr(32'h4, 4'b1111, 32'd3);
    wr(32'h0, 4'b0001, 32'hB);
    A = 32'h8;
    step(5);
    check("ar_irq_e5", {31'd0, IRQ}, 32'd0);
    step(1);
    check("ar_irq_e6", {31'd0, IRQ}, 32'd1);
    step(1);
    check("ar_irq_e7", {31'd0, IRQ}, 32'd0);
    step(5);
    check("ar_irq_e12", {31'd0, IRQ}, 32'd1);
    step(1);
    check("ar_irq_e13", {31'd0, IRQ}, 32'd0);
    wr(32'h0, 4'b0001, 32'h3);
    A = 32'h8;
    for (int i = 0; i < 14; i++) begin
      step(1);
      check("ar_masked", {31'd0, IRQ}, 32'd0);
    end
    wr(32'h0, 4'b0001, 32'h0);
    step(2);

    // Pause at 4, resume reloads 10 two edges later.
    wr(32'h4, 4'b1111, 32'd10);
    wr(32'h0, 4'b0001, 32'h1);
    step(7);
    rd_chk("pr_count_5", 32'h8, 32'd5);
    wr(32'h0, 4'b0001, 32'h0);
    rd_chk("pr_count_4", 32'h8, 32'd4);
    step(4);
    rd_chk("pr_hold", 32'h8, 32'd4);
    wr(32'h0, 4'b0001, 32'h1);
    rd_chk("pr_re_e0", 32'h8, 32'd4);
    step(1);
    rd_chk("pr_re_e1", 32'h8, 32'd4);
    step(1);
    rd_chk("pr_reload", 32'h8, 32'd10);
    step(3);
    rd_chk("ar_pre_rst", 32'h8, 32'd7);

    // Asynchronous reset between edges.
    #1 reset = 1'b0;
    #1;
    check("arst_count", RD, 32'd0);
    check("arst_irq", {31'd0, IRQ}, 32'd0);
    rd_chk("arst_ctrl", 32'h0, 32'd0);
    rd_chk("arst_preset", 32'h4, 32'd0);
    step(2);
    reset = 1'b1;
    step(3);
    rd_chk("arst_idle", 32'h8, 32'd0);

    // PRESET=0 expires on the first counting cycle; CPU EN write wins in INT.
    wr(32'h4, 4'b1111, 32'd0);
    wr(32'h0, 4'b0001, 32'h9);
    step(2);
    check("p0_irq_e2", {31'd0, IRQ}, 32'd0);
    step(1);
    check("p0_irq_e3", {31'd0, IRQ}, 32'd1);
    wr(32'h0, 4'b0001, 32'h9);
    check("int_wr_irq", {31'd0, IRQ}, 32'd0);
    rd_chk("int_wr_en", 32'h0, 32'h9);
    step(3);
    check("int_wr_rerun", {31'd0, IRQ}, 32'd1);
    wr(32'h0, 4'b0001, 32'h0);
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
